// File: rtl/vga_timing_core.sv
// vga_timing_core: pixel-rate divider, h/v timing counters, sync/blank decode
// and gated RGB output. Optional colour-bar source: VGA_TEST_PATTERN_EN.
module vga_timing_core #(
    parameter int DIV      = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RGB_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RGB_W-1:0] in_rgb,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic             pix_tick,
    output logic [10:0]      pix_x,
    output logic [9:0]       pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
    localparam logic [10:0]   H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int B_W   = RGB_W / 3;
    localparam int G_W   = (RGB_W - B_W) / 2;
    localparam int R_W   = RGB_W - G_W - B_W;
`endif

    logic [CW-1:0]    tick_cnt;
    logic [10:0]      h_cnt;
    logic [9:0]       v_cnt;
    logic             h_last;
    logic             v_last;
    logic             hs_act;
    logic             vs_act;
    logic             vis;
    logic [RGB_W-1:0] colour;

`ifdef VGA_TEST_PATTERN_EN
    logic [10:0]      bar_q;
    logic [2:0]       bar_idx;
`endif

    assign pix_tick = (tick_cnt == TICK_LAST);
    assign h_last   = (h_cnt == H_LAST);
    assign v_last   = (v_cnt == V_LAST);
    assign pix_x    = h_cnt;
    assign pix_y    = v_cnt;

    // Pixel-rate divider: counts 0..DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (pix_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Raster counters: h wraps at line end and carries into v.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Decode sync windows, visibility and pixel colour from current counters.
    always_comb begin
        hs_act = (h_cnt >= 11'(HS_FIRST)) && (h_cnt <= 11'(HS_LAST));
        vs_act = (v_cnt >= 10'(VS_FIRST)) && (v_cnt <= 10'(VS_LAST));
        vis    = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
        colour = in_rgb;
`ifdef VGA_TEST_PATTERN_EN
        bar_q   = h_cnt / 11'(BAR_W);
        bar_idx = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
        if (test_mode) begin
            colour = {{R_W{bar_idx[2]}},
                      {G_W{bar_idx[1]}},
                      {B_W{bar_idx[0]}}};
        end
`endif
    end

    // Display outputs load on the tick edge, one pixel behind pix_x/pix_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && (h_cnt == '0) && (v_cnt == '0);
            if (pix_tick) begin
                hsync    <= hs_act ? HS_POL : ~HS_POL;
                vsync    <= vs_act ? VS_POL : ~VS_POL;
                video_on <= vis;
                rgb      <= vis ? colour : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core: reset, line/frame timing, rgb gating,
// small polarity-inverted geometry and asynchronous mid-frame reset.
module tb_vga_timing_core;

    localparam int HT = 800;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic [7:0]  in_rgb;

    logic        pt_m, hs_m, vs_m, vo_m, fs_m;
    logic [10:0] px_m;
    logic [9:0]  py_m;
    logic [7:0]  rgb_m;

    logic        pt_s, hs_s, vs_s, vo_s, fs_s;
    logic [10:0] px_s;
    logic [9:0]  py_s;
    logic [7:0]  rgb_s;

    int   n_cmp;
    int   n_bad;
    int   tk;
    bit   const_mode;
    logic fs_mid;
    logic pt_mid;
    logic [7:0] rgb_mid;

    // Default horizontal timing, vertical shrunk to 4/1/2/1 (8 lines).
    vga_timing_core #(
        .DIV(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_main (
        .clk(clk), .rst(rst), .in_rgb(in_rgb),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .pix_tick(pt_m), .pix_x(px_m), .pix_y(py_m),
        .hsync(hs_m), .vsync(vs_m), .video_on(vo_m),
        .rgb(rgb_m), .frame_start(fs_m)
    );

    vga_timing_core #(
        .DIV(1),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(rst2), .in_rgb(in_rgb),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .pix_tick(pt_s), .pix_x(px_s), .pix_y(py_s),
        .hsync(hs_s), .vsync(vs_s), .video_on(vo_s),
        .rgb(rgb_s), .frame_start(fs_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int n);
        return 8'((n * 7 + 3) & 255);
    endfunction

    // Advance one pixel period: a non-tick edge then a tick edge.
    task automatic step_tick();
        @(posedge clk); #1;
        fs_mid  = fs_m;
        pt_mid  = pt_m;
        rgb_mid = rgb_m;
        in_rgb  = const_mode ? 8'hFF : pat(tk + 1);
        @(posedge clk); #1;
        tk++;
        in_rgb  = const_mode ? 8'hFF : ~pat(tk + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; const_mode = 1'b0;
        in_rgb = pat(0);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (hs_m !== 1'b1) begin n_bad++; $display("FAIL rst_hsync got %b want 1", hs_m); end
        n_cmp++; if (vs_m !== 1'b1) begin n_bad++; $display("FAIL rst_vsync got %b want 1", vs_m); end
        n_cmp++; if (rgb_m !== 8'h00) begin n_bad++; $display("FAIL rst_rgb got %h want 00", rgb_m); end
        n_cmp++; if (px_m !== 11'd0) begin n_bad++; $display("FAIL rst_pix_x got %0d want 0", px_m); end
        n_cmp++; if (py_m !== 10'd0) begin n_bad++; $display("FAIL rst_pix_y got %0d want 0", py_m); end
        n_cmp++; if (vo_m !== 1'b0) begin n_bad++; $display("FAIL rst_video_on got %b want 0", vo_m); end
        n_cmp++; if (fs_m !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start got %b want 0", fs_m); end
        n_cmp++; if (hs_s !== 1'b0) begin n_bad++; $display("FAIL rst_hsync_pol1 got %b want 0", hs_s); end
        n_cmp++; if (vs_s !== 1'b0) begin n_bad++; $display("FAIL rst_vsync_pol1 got %b want 0", vs_s); end
        #3 rst = 1'b0;
        tk = -1;
        step_tick();
        n_cmp++; if (pt_mid !== 1'b1) begin n_bad++; $display("FAIL first_tick_clk1 got %b want 1", pt_mid); end
        n_cmp++; if (fs_mid !== 1'b0) begin n_bad++; $display("FAIL fs_before_tick got %b want 0", fs_mid); end
        n_cmp++; if (fs_m !== 1'b1) begin n_bad++; $display("FAIL fs_first_tick got %b want 1", fs_m); end
        n_cmp++; if (pt_m !== 1'b0) begin n_bad++; $display("FAIL tick_after_clk2 got %b want 0", pt_m); end
        n_cmp++; if (px_m !== 11'd1) begin n_bad++; $display("FAIL pix_x_after_first got %0d want 1", px_m); end
        n_cmp++; if (vo_m !== 1'b1) begin n_bad++; $display("FAIL video_on_first got %b want 1", vo_m); end
        n_cmp++; if (rgb_m !== pat(0)) begin n_bad++; $display("FAIL rgb_first got %h want %h", rgb_m, pat(0)); end
        step_tick();
        n_cmp++; if (pt_mid !== 1'b1) begin n_bad++; $display("FAIL tick_period got %b want 1", pt_mid); end
        n_cmp++; if (fs_m !== 1'b0) begin n_bad++; $display("FAIL fs_one_tick got %b want 0", fs_m); end
        n_cmp++; if (rgb_m !== pat(1)) begin n_bad++; $display("FAIL rgb_second got %h want %h", rgb_m, pat(1)); end
    endtask

    task automatic test_lines();
        int hs_low [2];
        int hs_first [2];
        int fall [2];
        int nfall;
        int e_pix, e_vid, e_rgb, e_hold, e_hs;
        int eh, ev, ln;
        logic prev_hs;
        logic [7:0] prev_rgb, exp_rgb;
        logic exp_vid, exp_hs;
        hs_low = '{0, 0}; hs_first = '{-1, -1}; fall = '{0, 0};
        nfall = 0; e_pix = 0; e_vid = 0; e_rgb = 0; e_hold = 0; e_hs = 0;
        prev_hs = hs_m; prev_rgb = pat(1);
        while (tk < 2 * HT - 1) begin
            step_tick();
            eh = tk % HT; ev = (tk / HT) % VT; ln = tk / HT;
            exp_vid = (eh < 640) && (ev < 4);
            exp_hs  = !((eh >= 656) && (eh <= 751));
            exp_rgb = exp_vid ? pat(tk) : 8'h00;
            if (hs_m === 1'b0) begin
                hs_low[ln]++;
                if (hs_first[ln] < 0) hs_first[ln] = eh;
            end
            if (prev_hs === 1'b1 && hs_m === 1'b0 && nfall < 2) begin
                fall[nfall] = tk; nfall++;
            end
            prev_hs = hs_m;
            if (px_m !== 11'((tk + 1) % HT) || py_m !== 10'(((tk + 1) / HT) % VT)) e_pix++;
            if (vo_m !== exp_vid) e_vid++;
            if (rgb_m !== exp_rgb) e_rgb++;
            if (fs_mid !== 1'b0 || fs_m !== 1'b0 || rgb_mid !== prev_rgb) e_hold++;
            if (hs_m !== exp_hs) e_hs++;
            prev_rgb = exp_rgb;
        end
        n_cmp++; if (hs_low[0] !== 96) begin n_bad++; $display("FAIL hs_width_l0 got %0d want 96", hs_low[0]); end
        n_cmp++; if (hs_low[1] !== 96) begin n_bad++; $display("FAIL hs_width_l1 got %0d want 96", hs_low[1]); end
        n_cmp++; if (hs_first[0] !== 656) begin n_bad++; $display("FAIL hs_start_l0 got %0d want 656", hs_first[0]); end
        n_cmp++; if (hs_first[1] !== 656) begin n_bad++; $display("FAIL hs_start_l1 got %0d want 656", hs_first[1]); end
        n_cmp++; if (fall[1] - fall[0] !== HT) begin n_bad++; $display("FAIL line_period got %0d want %0d", fall[1] - fall[0], HT); end
        n_cmp++; if (e_pix !== 0) begin n_bad++; $display("FAIL pix_xy_track errors %0d want 0", e_pix); end
        n_cmp++; if (e_vid !== 0) begin n_bad++; $display("FAIL video_on_lines errors %0d want 0", e_vid); end
        n_cmp++; if (e_rgb !== 0) begin n_bad++; $display("FAIL rgb_sample errors %0d want 0", e_rgb); end
        n_cmp++; if (e_hold !== 0) begin n_bad++; $display("FAIL hold_between_ticks errors %0d want 0", e_hold); end
        n_cmp++; if (e_hs !== 0) begin n_bad++; $display("FAIL hsync_decode errors %0d want 0", e_hs); end
    endtask

    task automatic test_frames();
        int vs_low, vs_first, fs_cnt, fs_a, fs_b;
        int on_cnt, ff_cnt, e_rgb, e_vs;
        int eh, ev;
        logic exp_vid;
        vs_low = 0; vs_first = -1; fs_cnt = 0; fs_a = -1; fs_b = -1;
        on_cnt = 0; ff_cnt = 0; e_rgb = 0; e_vs = 0;
        const_mode = 1'b1;
        in_rgb = 8'hFF;
        while (tk < 2 * FT) begin
            step_tick();
            eh = tk % HT; ev = (tk / HT) % VT;
            exp_vid = (eh < 640) && (ev < 4);
            if (fs_m === 1'b1) begin
                fs_cnt++;
                if (fs_a < 0) fs_a = tk; else if (fs_b < 0) fs_b = tk;
            end
            if (vs_m !== !((ev == 5) || (ev == 6))) e_vs++;
            if (tk >= FT && tk < 2 * FT) begin
                if (vs_m === 1'b0) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = tk - FT;
                end
                if (vo_m === 1'b1) on_cnt++;
                if (rgb_m === 8'hFF) ff_cnt++;
            end
            if (rgb_m !== (exp_vid ? 8'hFF : 8'h00)) e_rgb++;
        end
        n_cmp++; if (vs_low !== 2 * HT) begin n_bad++; $display("FAIL vs_width got %0d want %0d", vs_low, 2 * HT); end
        n_cmp++; if (vs_first !== 5 * HT) begin n_bad++; $display("FAIL vs_start got %0d want %0d", vs_first, 5 * HT); end
        n_cmp++; if (fs_cnt !== 2) begin n_bad++; $display("FAIL fs_count got %0d want 2", fs_cnt); end
        n_cmp++; if (fs_a !== FT) begin n_bad++; $display("FAIL fs_position got %0d want %0d", fs_a, FT); end
        n_cmp++; if (fs_b - fs_a !== FT) begin n_bad++; $display("FAIL fs_period got %0d want %0d", fs_b - fs_a, FT); end
        n_cmp++; if (on_cnt !== 4 * 640) begin n_bad++; $display("FAIL video_on_count got %0d want %0d", on_cnt, 4 * 640); end
        n_cmp++; if (ff_cnt !== 4 * 640) begin n_bad++; $display("FAIL rgb_ff_count got %0d want %0d", ff_cnt, 4 * 640); end
        n_cmp++; if (e_rgb !== 0) begin n_bad++; $display("FAIL rgb_gating errors %0d want 0", e_rgb); end
        n_cmp++; if (e_vs !== 0) begin n_bad++; $display("FAIL vsync_decode errors %0d want 0", e_vs); end
    endtask

    task automatic test_async_reset();
        const_mode = 1'b1;
        while (tk < 2 * FT + 3 * HT + 299) step_tick();
        n_cmp++; if (px_m !== 11'd300 || py_m !== 10'd3) begin n_bad++; $display("FAIL pre_reset_xy got %0d,%0d want 300,3", px_m, py_m); end
        n_cmp++; if (vo_m !== 1'b1) begin n_bad++; $display("FAIL pre_reset_video got %b want 1", vo_m); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (px_m !== 11'd0 || py_m !== 10'd0) begin n_bad++; $display("FAIL async_xy got %0d,%0d want 0,0", px_m, py_m); end
        n_cmp++; if (vo_m !== 1'b0) begin n_bad++; $display("FAIL async_video got %b want 0", vo_m); end
        n_cmp++; if (rgb_m !== 8'h00) begin n_bad++; $display("FAIL async_rgb got %h want 00", rgb_m); end
        n_cmp++; if (hs_m !== 1'b1 || vs_m !== 1'b1) begin n_bad++; $display("FAIL async_sync got %b%b want 11", hs_m, vs_m); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (px_m !== 11'd0 || fs_m !== 1'b0) begin n_bad++; $display("FAIL held_reset got x=%0d fs=%b want 0,0", px_m, fs_m); end
        #3 rst = 1'b0;
        tk = -1;
        step_tick();
        n_cmp++; if (fs_mid !== 1'b0) begin n_bad++; $display("FAIL restart_fs_early got %b want 0", fs_mid); end
        n_cmp++; if (fs_m !== 1'b1) begin n_bad++; $display("FAIL restart_fs got %b want 1", fs_m); end
        n_cmp++; if (px_m !== 11'd1 || py_m !== 10'd0) begin n_bad++; $display("FAIL restart_xy got %0d,%0d want 1,0", px_m, py_m); end
        step_tick();
        n_cmp++; if (fs_m !== 1'b0) begin n_bad++; $display("FAIL restart_fs_clear got %b want 0", fs_m); end
    endtask

    task automatic test_small_geometry();
        int e_hs, e_vs, e_vo, e_fs, e_xy, e_pt, e_rgb, hs_hi, vs_hi, fs_n;
        int eh, ev;
        logic exp_vo;
        e_hs = 0; e_vs = 0; e_vo = 0; e_fs = 0; e_xy = 0; e_pt = 0; e_rgb = 0;
        hs_hi = 0; vs_hi = 0; fs_n = 0;
        in_rgb = 8'hC3;
        #3 rst2 = 1'b0;
        for (int k = 0; k < 96; k++) begin
            @(posedge clk); #1;
            eh = k % 8; ev = (k / 8) % 6;
            exp_vo = (eh < 4) && (ev < 3);
            if (hs_s !== ((eh == 5) || (eh == 6))) e_hs++;
            if (vs_s !== (ev == 4)) e_vs++;
            if (vo_s !== exp_vo) e_vo++;
            if (fs_s !== ((k % 48) == 0)) e_fs++;
            if (px_s !== 11'((k + 1) % 8) || py_s !== 10'(((k + 1) / 8) % 6)) e_xy++;
            if (pt_s !== 1'b1) e_pt++;
            if (rgb_s !== (exp_vo ? 8'hC3 : 8'h00)) e_rgb++;
            if (hs_s === 1'b1) hs_hi++;
            if (vs_s === 1'b1) vs_hi++;
            if (fs_s === 1'b1) fs_n++;
        end
        n_cmp++; if (e_hs !== 0) begin n_bad++; $display("FAIL small_hsync errors %0d want 0", e_hs); end
        n_cmp++; if (e_vs !== 0) begin n_bad++; $display("FAIL small_vsync errors %0d want 0", e_vs); end
        n_cmp++; if (e_vo !== 0) begin n_bad++; $display("FAIL small_video errors %0d want 0", e_vo); end
        n_cmp++; if (e_fs !== 0) begin n_bad++; $display("FAIL small_fs errors %0d want 0", e_fs); end
        n_cmp++; if (e_xy !== 0) begin n_bad++; $display("FAIL small_xy errors %0d want 0", e_xy); end
        n_cmp++; if (e_pt !== 0) begin n_bad++; $display("FAIL small_tick errors %0d want 0", e_pt); end
        n_cmp++; if (e_rgb !== 0) begin n_bad++; $display("FAIL small_rgb errors %0d want 0", e_rgb); end
        n_cmp++; if (hs_hi !== 24) begin n_bad++; $display("FAIL small_hs_count got %0d want 24", hs_hi); end
        n_cmp++; if (vs_hi !== 16) begin n_bad++; $display("FAIL small_vs_count got %0d want 16", vs_hi); end
        n_cmp++; if (fs_n !== 2) begin n_bad++; $display("FAIL small_fs_count got %0d want 2", fs_n); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; tk = 0;
        rst = 1'b1; rst2 = 1'b1; in_rgb = 8'h00; const_mode = 1'b0;
        test_reset();
        test_lines();
        test_frames();
        test_async_reset();
        test_small_geometry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_core.md
Name: vga_timing_core

Overview:
Parametrised VGA timing and pixel-output engine. It generalises the current fixed 640x480 controller and external frequency divider into one block. It generates an internal pixel-rate enable from the system clock, horizontal and vertical counters with generic porch/sync timing, programmable sync polarity, pixel coordinates, blanking and frame markers, and gated multi-bit RGB output. It sits between the top-level core and the board VGA pins, and replaces the separate divider and controller instances.

Parameters:
DIV, 2, system clocks per pixel (>=1); 100 MHz/4 or 50 MHz/2 gives a 25 MHz pixel rate
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of hsync
VS_POL, 0, active level of vsync
RGB_W, 8, colour bus width (default packing R3 G3 B2)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous, active-high
in_rgb  in  RGB_W  pixel colour for the coordinate on pix_x/pix_y
pix_tick  out  1  one-clk pixel enable; every counter/output update happens on a clk edge where pix_tick=1
pix_x  out  11  current horizontal counter (0..H_TOTAL-1)
pix_y  out  10  current vertical counter (0..V_TOTAL-1)
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
video_on  out  1  high while the displayed pixel is inside the active area
rgb  out  RGB_W  registered colour; 0 while blanked
frame_start  out  1  one-clk pulse when pixel (0,0) is loaded onto the display outputs

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Divider: tick counter counts 0..DIV-1 and wraps. pix_tick=1 on the cycle the counter equals DIV-1. With DIV=1, pix_tick is constantly 1 after reset.
- On each tick edge, the h counter increments. At H_TOTAL-1 it wraps to 0 and the v counter increments. The v counter wraps from V_TOTAL-1 to 0 on the same edge as the h wrap.
- pix_x/pix_y drive the counter registers directly. The user presents in_rgb for that coordinate; in_rgb is sampled on the tick edge.
- Display outputs (hsync, vsync, video_on, rgb, frame_start) are registered on the tick edge from the pre-increment counters. They therefore lag pix_x/pix_y by exactly one pixel period and hold for DIV clocks.
- Decode rules:
  - hsync = HS_POL when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL.
  - vsync is decoded the same way on v, using V_* and VS_POL.
  - video_on = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - rgb = video_on ? in_rgb : 0.
  - frame_start = 1 for one clk when the loaded pixel is h=0 and v=0; it also clears on non-tick edges.
- Reset (asynchronous; applies immediately, including mid-frame):
  - tick counter, h, v, rgb, video_on and frame_start = 0.
  - hsync = ~HS_POL; vsync = ~VS_POL.
  - After release, the first pix_tick occurs on the DIV-th clk. That first tick loads pixel (0,0), so frame_start pulses on the first tick.
- No other inputs. in_rgb changing between ticks has no effect.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds input port test_mode (1 bit). When test_mode=1, in_rgb is ignored and the active area shows 8 vertical colour bars, each H_ACTIVE/8 wide. The bar index is h[...] scaled, and bar colours are R=bit2, G=bit1, B=bit0 of the index, replicated to full channel width. Blanking, sync and frame_start are unchanged.
- Undefined: test_mode port absent; rgb always comes from in_rgb.

Test Plan:
1. DIV=2, rst held 5 clks then released -> during reset hsync=1, vsync=1, rgb=0, pix_x=pix_y=0. First pix_tick on clk 2 after release, period 2, and frame_start pulses on that tick.
2. Defaults, run 2 lines -> hsync low for exactly 96 ticks, starting on the tick after the one where pix_x=656. Line period is 800 ticks (1600 clks).
3. Defaults, run 2 frames -> vsync low for exactly 2 lines (1600 ticks), starting at line 490. frame_start period is 420000 ticks (840000 clks).
4. in_rgb=8'hFF constant -> rgb=8'hFF and video_on=1 for 640 ticks on each of lines 0..479; rgb=0 and video_on=0 for all other ticks.
5. HS_POL=1, VS_POL=1, H=4/1/2/1, V=3/1/1/1, DIV=1 -> H_TOTAL=8, V_TOTAL=6. hsync is high on h=5,6 and vsync is high on v=4; the frame repeats every 48 clks.
6. Assert rst asynchronously at line 100, x=300 (between clk edges) -> all outputs return to reset values without waiting for a clk edge. After release, the frame restarts at (0,0) with a frame_start pulse.
